// File: rtl/uart_tx_engine.sv
// Parametrised UART transmit serializer: start bit, 5..MAX_DATA_WIDTH data bits (LSB first),
// optional even/odd parity, 1-2 stop bits. Define UART_TX_ERR_INJECT_EN to add error-injection inputs.
module uart_tx_engine #(
  parameter int MAX_DATA_WIDTH = 8,
  parameter int DIV_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [MAX_DATA_WIDTH-1:0] txData,
  input  logic                      txValid,
  output logic                      txReady,
  input  logic [3:0]                cfgDataWidth,
  input  logic                      cfgParityEnable,
  input  logic                      cfgParityType,
  input  logic [1:0]                cfgStopBits,
  input  logic [4:0]                cfgOverSampling,
  input  logic [DIV_WIDTH-1:0]      cfgBaudDivisor,
`ifdef UART_TX_ERR_INJECT_EN
  input  logic                      injParityError,
  input  logic                      injFramingError,
`endif
  output logic                      txSerial,
  output logic                      txBusy,
  output logic                      txDone
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  localparam logic [3:0] MAX_W = 4'(MAX_DATA_WIDTH);

  state_t                    r_state;
  state_t                    w_next_state;

  logic [MAX_DATA_WIDTH-1:0] r_shift;
  logic [3:0]                r_width;
  logic                      r_par_en;
  logic                      r_parity;
  logic [1:0]                r_stop;
  logic [4:0]                r_os;
  logic [DIV_WIDTH-1:0]      r_div;
  logic                      r_frame_err;
  logic [DIV_WIDTH-1:0]      r_div_cnt;
  logic [4:0]                r_tick_cnt;
  logic [3:0]                r_bit_cnt;
  logic                      r_done;

  logic [3:0]                w_width;
  logic [1:0]                w_stop;
  logic [4:0]                w_os;
  logic [DIV_WIDTH-1:0]      w_div;
  logic [MAX_DATA_WIDTH-1:0] w_masked;
  logic                      w_parity;
  logic                      w_inj_par;
  logic                      w_inj_frm;
  logic                      w_accept;
  logic                      w_tick;
  logic                      w_bit_end;
  logic                      w_last_data;
  logic                      w_last_stop;

`ifdef UART_TX_ERR_INJECT_EN
  assign w_inj_par = injParityError;
  assign w_inj_frm = injFramingError;
`else
  assign w_inj_par = 1'b0;
  assign w_inj_frm = 1'b0;
`endif

  assign w_accept = txValid && (r_state == ST_IDLE);

  // Configuration is sanitised once, on the way into the frame registers.
  always_comb begin
    w_width = cfgDataWidth;
    if (cfgDataWidth < 4'd5) begin
      w_width = 4'd5;
    end else if (cfgDataWidth > MAX_W) begin
      w_width = MAX_W;
    end
  end

  assign w_stop = (cfgStopBits == 2'd0) ? 2'd1 :
                  (cfgStopBits == 2'd3) ? 2'd2 : cfgStopBits;
  assign w_os   = (cfgOverSampling == 5'd13) ? 5'd13 : 5'd16;
  assign w_div  = (cfgBaudDivisor == '0) ? DIV_WIDTH'(1) : cfgBaudDivisor;

  // NOTE: every variable driven in an always_comb gets a default first, so no path infers a latch.
  always_comb begin
    w_masked = '0;
    for (int i = 0; i < MAX_DATA_WIDTH; i++) begin
      if (i < int'(w_width)) begin
        w_masked[i] = txData[i];
      end
    end
  end

  assign w_parity = (^w_masked) ^ cfgParityType ^ w_inj_par;

  assign w_tick      = (r_div_cnt == r_div - DIV_WIDTH'(1));
  assign w_bit_end   = w_tick && (r_tick_cnt == r_os - 5'd1);
  assign w_last_data = (r_bit_cnt == r_width - 4'd1);
  assign w_last_stop = (r_bit_cnt == {2'b00, r_stop} - 4'd1);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept)  w_next_state = ST_START;
      ST_START:  if (w_bit_end) w_next_state = ST_DATA;
      ST_DATA: begin
        if (w_bit_end && w_last_data) begin
          w_next_state = r_par_en ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: if (w_bit_end) w_next_state = ST_STOP;
      ST_STOP:   if (w_bit_end && w_last_stop) w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    txSerial = 1'b1;
    txBusy   = 1'b1;
    txReady  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        txBusy  = 1'b0;
        txReady = 1'b1;
      end
      ST_START:  txSerial = 1'b0;
      ST_DATA:   txSerial = r_shift[0];
      ST_PARITY: txSerial = r_parity;
      // An injected framing error only corrupts the first stop bit.
      ST_STOP:   txSerial = ~(r_frame_err && (r_bit_cnt == 4'd0));
      default:   txSerial = 1'b1;
    endcase
  end

  assign txDone = r_done;

  // NOTE: the datapath is plain flops, so it is all cleared by reset; an abandoned frame leaves nothing behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift     <= '0;
      r_width     <= '0;
      r_par_en    <= 1'b0;
      r_parity    <= 1'b0;
      r_stop      <= '0;
      r_os        <= '0;
      r_div       <= '0;
      r_frame_err <= 1'b0;
      r_div_cnt   <= '0;
      r_tick_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= (r_state == ST_STOP) && (w_next_state == ST_IDLE);
      if (w_accept) begin
        r_shift     <= w_masked;
        r_width     <= w_width;
        r_par_en    <= cfgParityEnable;
        r_parity    <= w_parity;
        r_stop      <= w_stop;
        r_os        <= w_os;
        r_div       <= w_div;
        r_frame_err <= w_inj_frm;
        r_div_cnt   <= '0;
        r_tick_cnt  <= '0;
        r_bit_cnt   <= '0;
      end else if (r_state != ST_IDLE) begin
        r_div_cnt <= w_tick ? '0 : r_div_cnt + DIV_WIDTH'(1);
        if (w_tick) begin
          r_tick_cnt <= w_bit_end ? 5'd0 : r_tick_cnt + 5'd1;
        end
        if (w_bit_end) begin
          if (r_state == ST_DATA) begin
            r_shift <= {1'b0, r_shift[MAX_DATA_WIDTH-1:1]};
          end
          // The bit counter indexes bits within the current state only.
          r_bit_cnt <= (w_next_state != r_state) ? 4'd0 : r_bit_cnt + 4'd1;
        end
      end
    end
  end

endmodule
